param_cache: RTL and testbench
==============================

PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 Parameter DATA_W, 32, data width in bits.
REQ-002 Parameter ADDR_W, 32, word-address width in bits.
REQ-003 Parameter LINES, 4, number of direct-mapped lines; power of two, at least 2; IDX_W = log2(LINES).
REQ-004 Parameter CNT_W, 16, statistics counter width.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port req_valid  input  1  CPU request present.
REQ-008 Port req_ready  output  1  cache accepts a request this cycle.
REQ-009 Port req_wr  input  1  1 = write, 0 = read.
REQ-010 Port req_addr  input  ADDR_W  word address; index = req_addr[IDX_W-1:0], tag = req_addr >> IDX_W.
REQ-011 Port req_wdata  input  DATA_W  write data.
REQ-012 Port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 Port rsp_rdata  output  DATA_W  read data, valid while rsp_valid = 1.
REQ-014 Port rsp_miss  output  1  completed access was a miss, valid while rsp_valid = 1.
REQ-015 Port flush  input  1  invalidate all lines.
REQ-016 Port mem_req / mem_wr  output  1 each  backing-memory request and direction.
REQ-017 Port mem_addr / mem_wdata  output  ADDR_W / DATA_W  backing-memory address and write data.
REQ-018 Port mem_ack / mem_rdata  input  1 / DATA_W  memory completion and read data.
REQ-019 Port hit_cnt / miss_cnt  output  CNT_W each  access statistics.

Function
REQ-020 FSM states IDLE, LOOKUP, MEM; req_ready = (state == IDLE) && !flush.
REQ-021 Request is accepted on an edge where req_valid && req_ready; wr, addr and wdata are registered; the next state is LOOKUP.
REQ-022 LOOKUP lasts one cycle; hit = valid[index] && tag_array[index] == tag.
REQ-023 Read hit: at the end of LOOKUP, rsp_valid = 1, rsp_rdata = line data, rsp_miss = 0; next state IDLE (response in the 2nd cycle after acceptance).
REQ-024 Read miss or any write: LOOKUP -> MEM; mem_req = 1, mem_wr = registered wr, mem_addr = registered addr, mem_wdata = registered wdata, held stable until mem_ack is sampled 1.
REQ-025 Read miss on the mem_ack edge: line is filled (valid = 1, tag, data = mem_rdata); rsp_rdata = mem_rdata; rsp_miss = 1; rsp_valid pulses; next state IDLE.
REQ-026 Write is write-through and no-allocate: on the mem_ack edge, a hit updates line data with wdata; a miss leaves the arrays unchanged; rsp_valid pulses with rsp_miss = !hit; rsp_rdata holds its previous value.
REQ-027 mem_req deasserts in the cycle after the ack; mem_ack while mem_req = 0 is ignored; memory latency is unbounded.
REQ-028 flush is honoured only in IDLE: all valid bits are cleared in one edge; flush wins over a simultaneous req_valid; flush in LOOKUP or MEM is ignored.
REQ-029 rsp_valid is high for exactly one cycle per accepted request; there is at most one request outstanding.

Reset
REQ-030 rst_n low asynchronously forces state IDLE and all valid bits 0, and sets req_ready to 1 (unless flush is high) and rsp_valid, rsp_miss, rsp_rdata, mem_req, mem_wr, mem_addr, mem_wdata, hit_cnt and miss_cnt to 0.
REQ-031 Reset during LOOKUP or MEM aborts the access: no fill and no response; tag and data arrays need no reset.

Configuration
REQ-032 Macro PARAM_CACHE_STATS_EN defined: hit_cnt increments on every read or write hit and miss_cnt on every read or write miss, each at its rsp_valid edge; both saturate at all-ones; flush does not clear them.
REQ-033 Macro PARAM_CACHE_STATS_EN undefined: no counter flops; hit_cnt and miss_cnt are tied to 0; the ports remain.

Verification
REQ-034 LINES = 4, after reset: read 0x5, memory acks 3 cycles later with 0xDEADBEEF -> one mem_req (read, addr 0x5), rsp_rdata 0xDEADBEEF, rsp_miss 1; re-read 0x5 -> no mem_req, rsp_valid 2 cycles after acceptance, rsp_miss 0.
REQ-035 Conflict: read 0x1, read 0x5, read 0x1 -> three misses, three mem reads; miss_cnt 3.
REQ-036 Write 0x5 = 0x12345678 while 0x5 is cached -> mem write 0x12345678 to 0x5, rsp_miss 0; read 0x5 -> hit, rsp_rdata 0x12345678.
REQ-037 Write miss to 0x9, then read 0x9 -> write rsp_miss 1; the read also misses (no-allocate).
REQ-038 Fill 0x1; assert flush together with req_valid (read 0x1) -> req_ready 0 that cycle; request accepted next cycle and misses.
REQ-039 rst_n low while in MEM -> mem_req 0 immediately, no rsp_valid; with STATS_EN and CNT_W = 2, five hits -> hit_cnt = 3.

Source files
------------

// File: rtl/param_cache_if.sv
// ---------------------------------------------------------------------------
// param_cache_if -- request / response / backing-memory bundle for param_cache
//
// Signals
//   req_valid, req_wr, req_addr, req_wdata : CPU request (req_ready back-pressure)
//   rsp_valid, rsp_rdata, rsp_miss         : one-cycle completion report
//   mem_req, mem_wr, mem_addr, mem_wdata   : backing-memory request
//   mem_ack, mem_rdata                     : backing-memory completion
//
// Modports
//   slave  : the cache's view (consumes requests, drives the memory bus)
//   master : the environment's view (CPU + memory model)
// ---------------------------------------------------------------------------
interface param_cache_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_miss;

  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_miss,
           mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_miss,
           mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/param_cache.sv
// ---------------------------------------------------------------------------
// param_cache -- direct-mapped, write-through, no-write-allocate cache
//
// One request is in flight at a time. A request is accepted in IDLE, the
// tags are checked in a single LOOKUP cycle, and read misses and all writes
// go to the backing memory in MEM until mem_ack.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   flush    : invalidate all lines (only honoured in IDLE)
//   bus      : param_cache_if.slave (request, response, memory bus)
//   hit_cnt  : saturating hit counter   (PARAM_CACHE_STATS_EN only, else 0)
//   miss_cnt : saturating miss counter  (PARAM_CACHE_STATS_EN only, else 0)
//
// Configuration
//   PARAM_CACHE_STATS_EN : define to build the hit/miss statistics counters.
// ---------------------------------------------------------------------------
module param_cache #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LINES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  param_cache_if.slave     bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM} state_t;

  state_t            state, state_next;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_array  [LINES];
  logic [DATA_W-1:0] data_array [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;

  logic              accept;
  logic              do_flush;
  logic              rd_hit_done;
  logic              go_mem;
  logic              mem_done;
  logic              done;
  logic              done_miss;

  // The arrays only change on mem_done or flush, so the lookup result stays
  // valid for the whole MEM phase and can be reused on the ack edge.
  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];
  assign hit = valid[idx] && (tag_array[idx] == tag);

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    do_flush      = 1'b0;
    rd_hit_done   = 1'b0;
    go_mem        = 1'b0;
    mem_done      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !flush;
        if (flush) begin
          do_flush = 1'b1;
        end else if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!wr_q && hit) begin
          rd_hit_done = 1'b1;
          state_next  = IDLE;
        end else begin
          go_mem     = 1'b1;
          state_next = MEM;
        end
      end
      MEM: begin
        // mem_req is high for the whole of MEM, so an ack here is a real one.
        if (bus.mem_ack) begin
          mem_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign done      = rd_hit_done || mem_done;
  assign done_miss = mem_done && (!wr_q || !hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request capture, response and memory-bus registers, valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      valid         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_miss  <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end

      if (do_flush)
        valid <= '0;
      else if (mem_done && !wr_q)
        valid[idx] <= 1'b1;

      bus.rsp_valid <= done;
      if (done)
        bus.rsp_miss <= done_miss;
      // Writes leave rsp_rdata at whatever the last read returned.
      if (rd_hit_done)
        bus.rsp_rdata <= data_array[idx];
      else if (mem_done && !wr_q)
        bus.rsp_rdata <= bus.mem_rdata;

      if (go_mem) begin
        bus.mem_req   <= 1'b1;
        bus.mem_wr    <= wr_q;
        bus.mem_addr  <= addr_q;
        bus.mem_wdata <= wdata_q;
      end else if (mem_done) begin
        bus.mem_req <= 1'b0;
      end
    end
  end

  // Tag/data storage is not reset; the valid bits make stale contents harmless.
  always_ff @(posedge clk) begin
    if (mem_done && !wr_q) begin
      tag_array[idx]  <= tag;
      data_array[idx] <= bus.mem_rdata;
    end else if (mem_done && wr_q && hit) begin
      data_array[idx] <= wdata_q;
    end
  end

`ifdef PARAM_CACHE_STATS_EN
  // Counters step on the same edge that raises rsp_valid and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (done) begin
      if (done_miss) begin
        if (miss_cnt != {CNT_W{1'b1}})
          miss_cnt <= miss_cnt + CNT_W'(1);
      end else begin
        if (hit_cnt != {CNT_W{1'b1}})
          hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_param_cache.sv
// ---------------------------------------------------------------------------
// tb_param_cache -- self-checking bench for param_cache (LINES = 4, CNT_W = 2)
//
// The reference model holds per-line valid/tag/data arrays, an associative
// backing memory and saturating hit/miss counts, and predicts each access's
// response, latency and memory traffic from the cache rules.
// ---------------------------------------------------------------------------
module tb_param_cache;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LINES  = 4;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  param_cache_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  param_cache #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LINES (LINES),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus.slave),
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_rdata = 0;
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int expHitCnt();
`ifdef PARAM_CACHE_STATS_EN
    return exp_hits;
`else
    return 0;
`endif
  endfunction

  function automatic int expMissCnt();
`ifdef PARAM_CACHE_STATS_EN
    return exp_misses;
`else
    return 0;
`endif
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    last_rdata = 0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  // One complete access: present, get accepted, serve memory, check response.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int delay, input bit pre_flush, input bit lookup_flush);
    int          idx;
    logic [31:0] tg;
    bit          hit;
    bit          uses_mem;
    logic [31:0] memval;
    logic [31:0] exp_rdata;
    bit          exp_miss;
    int          exp_lat;
    bit          got_rsp = 0;
    int          lat = 0;
    int          mem_cycles = 0;
    logic [31:0] obs_rdata = 0;
    logic        obs_miss = 0;
    logic        mem_req_at_rsp = 0;

    @(posedge clk); #1;
    bus.mem_ack   = 0;
    bus.req_valid = 1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    if (pre_flush) begin
      flush = 1;
      #1 checkOutput("ready_during_flush", bus.req_ready, 0);
      @(posedge clk); #1;
      flush = 0;
      for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    end
    #1 checkOutput("ready_idle", bus.req_ready, 1);

    // Prediction from the model
    idx = int'(addr % LINES);
    tg  = addr / LINES;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    uses_mem = wr || !hit;
    if (!mem_model.exists(addr)) mem_model[addr] = $urandom;
    memval  = mem_model[addr];
    exp_lat = uses_mem ? 3 + delay : 2;
    if (wr) begin
      exp_rdata = last_rdata;
      exp_miss  = !hit;
    end else begin
      exp_rdata = hit ? m_data[idx] : memval;
      exp_miss  = !hit;
    end

    @(posedge clk); #1;
    bus.req_valid = 0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    for (int k = 1; k <= 60 && !got_rsp; k++) begin
      flush = (k == 1) && lookup_flush;
      if (bus.rsp_valid) begin
        got_rsp        = 1;
        lat            = k;
        obs_rdata      = bus.rsp_rdata;
        obs_miss       = bus.rsp_miss;
        mem_req_at_rsp = bus.mem_req;
        bus.mem_ack    = 0;
      end else begin
        if (bus.mem_req) begin
          checkOutput("mem_wr", bus.mem_wr, wr);
          checkOutput("mem_addr", bus.mem_addr, addr);
          checkOutput("mem_wdata", bus.mem_wdata, wdata);
          bus.mem_ack   = (mem_cycles == delay);
          bus.mem_rdata = (mem_cycles == delay && !wr) ? memval : $urandom;
          mem_cycles++;
        end else begin
          // Acks without a pending request must be ignored.
          bus.mem_ack   = ($urandom_range(0, 3) == 0);
          bus.mem_rdata = $urandom;
        end
        @(posedge clk); #1;
      end
    end
    flush = 0;
    bus.mem_ack = 0;

    // Model update
    if (wr) begin
      mem_model[addr] = wdata;
      if (hit) m_data[idx] = wdata;
    end else begin
      if (!hit) begin
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
        m_data[idx]  = memval;
      end
      last_rdata = exp_rdata;
    end
    if (exp_miss) begin
      if (exp_misses < CNT_MAX) exp_misses++;
    end else begin
      if (exp_hits < CNT_MAX) exp_hits++;
    end

    checkOutput("rsp_seen", got_rsp, 1);
    checkOutput("rsp_latency", lat, exp_lat);
    checkOutput("rsp_rdata", obs_rdata, exp_rdata);
    checkOutput("rsp_miss", obs_miss, exp_miss);
    checkOutput("mem_cycles", mem_cycles, uses_mem ? delay + 1 : 0);
    checkOutput("mem_req_after_ack", mem_req_at_rsp, 0);
    checkOutput("hit_cnt", hit_cnt, expHitCnt());
    checkOutput("miss_cnt", miss_cnt, expMissCnt());
    @(posedge clk); #1;
    checkOutput("rsp_pulse_width", bus.rsp_valid, 0);
  endtask

  // Start a read miss, then pull reset while the memory access is pending.
  task automatic resetDuringMem(input logic [31:0] addr);
    bit seen = 0;
    @(posedge clk); #1;
    bus.req_valid = 1;
    bus.req_wr    = 0;
    bus.req_addr  = addr;
    bus.req_wdata = $urandom;
    @(posedge clk); #1;
    bus.req_valid = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (bus.mem_req) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("rst_mem_req_seen", seen, 1);
    rst_n = 0;
    #1;
    checkOutput("rst_mem_req_drop", bus.mem_req, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_req_ready", bus.req_ready, 1);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    modelReset();
    bus.mem_ack   = 1;
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    checkOutput("rst_no_rsp", bus.rsp_valid, 0);
    rst_n = 1;
    bus.mem_ack = 0;
    @(posedge clk); #1;
    checkOutput("rst_no_rsp_after", bus.rsp_valid, 0);
    checkOutput("rst_no_mem_req_after", bus.mem_req, 0);
  endtask

  initial begin
    rst_n         = 0;
    flush         = 0;
    bus.req_valid = 0;
    bus.req_wr    = 0;
    bus.req_addr  = 0;
    bus.req_wdata = 0;
    bus.mem_ack   = 0;
    bus.mem_rdata = 0;
    modelReset();

    #1;
    $display("[TB] checking reset state");
    checkOutput("reset_req_ready", bus.req_ready, 1);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_miss", bus.rsp_miss, 0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("reset_mem_req", bus.mem_req, 0);
    checkOutput("reset_mem_wr", bus.mem_wr, 0);
    checkOutput("reset_mem_addr", bus.mem_addr, 0);
    checkOutput("reset_mem_wdata", bus.mem_wdata, 0);
    checkOutput("reset_hit_cnt", hit_cnt, 0);
    checkOutput("reset_miss_cnt", miss_cnt, 0);
    flush = 1;
    #1 checkOutput("reset_ready_flush", bus.req_ready, 0);
    flush = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    $display("[TB] directed sequences");
    mem_model[32'h5] = 32'hDEADBEEF;
    applyStimulus(0, 32'h5, $urandom, 3, 0, 0);
    applyStimulus(0, 32'h5, $urandom, 0, 0, 0);
    applyStimulus(0, 32'h1, $urandom, 1, 0, 0);
    applyStimulus(0, 32'h5, $urandom, 2, 0, 0);
    applyStimulus(0, 32'h1, $urandom, 0, 0, 0);
    applyStimulus(0, 32'h5, $urandom, 1, 0, 0);
    applyStimulus(1, 32'h5, 32'h12345678, 2, 0, 0);
    applyStimulus(0, 32'h5, $urandom, 0, 0, 0);
    applyStimulus(1, 32'h9, $urandom, 1, 0, 0);
    applyStimulus(0, 32'h9, $urandom, 0, 0, 0);
    applyStimulus(0, 32'h1, $urandom, 0, 0, 0);
    applyStimulus(0, 32'h1, $urandom, 1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 32'h1, $urandom, 0, 0, 0);
    resetDuringMem(32'hABC0);
    applyStimulus(0, 32'hABC0, $urandom, 1, 0, 0);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 9) < 3,
                    32'($urandom_range(0, 15)),
                    $urandom,
                    $urandom_range(0, 4),
                    $urandom_range(0, 14) == 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
